// File: rtl/pipelined_multiplier_array.sv
// Elastic multiplier array for the sparse tensor core datapath.
// N_UNIT lanes each multiply one operand pair per beat. Every beat carries its
// own signed/unsigned mode and sparsity mask. Masked lanes are operand-gated.
// A PIPE_STAGES-deep valid/ready pipeline carries the products and the
// popcount of the mask to the adder tree. A saturating counter tracks
// completed output beats.

// One multiplier lane. Operands are forced to zero when the lane is pruned.
module mult_lane #(
    parameter int DW_IN  = 8,
    parameter int DW_OUT = 16
) (
    input  logic [DW_IN-1:0]  a,
    input  logic [DW_IN-1:0]  b,
    input  logic              mask,
    input  logic              sgn,
    output logic [DW_OUT-1:0] prod
);
    logic signed [DW_IN:0]     ax;
    logic signed [DW_IN:0]     bx;
    logic signed [2*DW_IN+1:0] full;

    // One extra bit per operand lets a single signed multiplier cover both modes.
    always_comb begin
        ax = '0;
        bx = '0;
        if (mask) begin
            ax = {sgn & a[DW_IN-1], a};
            bx = {sgn & b[DW_IN-1], b};
        end
        full = ax * bx;
        prod = DW_OUT'(full);
    end
endmodule

module pipelined_multiplier_array #(
    parameter int TILE_M      = 4,
    parameter int TILE_K      = 8,
    parameter int TILE_N      = 4,
    parameter int N_UNIT      = TILE_M * TILE_K * TILE_N,
    parameter int DW_IN       = 8,
    parameter int DW_OUT      = 2 * DW_IN,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [N_UNIT*DW_IN-1:0]    in_a,
    input  logic [N_UNIT*DW_IN-1:0]    in_b,
    input  logic [N_UNIT-1:0]          in_mask,
    input  logic                       in_signed,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [N_UNIT*DW_OUT-1:0]   out,
    output logic [$clog2(N_UNIT+1)-1:0] out_active,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CNT_W-1:0]           beat_count
);
    localparam int AW   = $clog2(N_UNIT+1);
    localparam int LAST = PIPE_STAGES - 1;

    typedef logic [N_UNIT-1:0][DW_OUT-1:0] prod_t;

    logic [N_UNIT-1:0][DW_IN-1:0] a_lane;
    logic [N_UNIT-1:0][DW_IN-1:0] b_lane;
    prod_t                        prod_c;
    logic [AW-1:0]                pop_c;

    prod_t                        data_pipe [PIPE_STAGES];
    logic [AW-1:0]                act_pipe  [PIPE_STAGES];
    logic [PIPE_STAGES-1:0]       vld_pipe;
    logic [PIPE_STAGES-1:0]       adv;

    prod_t                        din  [PIPE_STAGES];
    logic [AW-1:0]                ain  [PIPE_STAGES];
    logic [PIPE_STAGES-1:0]       vin;

    assign a_lane = in_a;
    assign b_lane = in_b;

    genvar g;
    generate
        for (g = 0; g < N_UNIT; g++) begin : g_lane
            mult_lane #(.DW_IN(DW_IN), .DW_OUT(DW_OUT)) u_lane (
                .a    (a_lane[g]),
                .b    (b_lane[g]),
                .mask (in_mask[g]),
                .sgn  (in_signed),
                .prod (prod_c[g])
            );
        end
    endgenerate

    // Number of live lanes in the incoming beat.
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < N_UNIT; i++)
            pop_c = pop_c + AW'(in_mask[i]);
    end

    // A stage may advance unless it and every stage after it are full while the sink stalls.
    always_comb begin
        logic full;
        adv = '0;
        for (int i = 0; i < PIPE_STAGES; i++) begin
            full = 1'b1;
            for (int j = i; j < PIPE_STAGES; j++)
                full = full & vld_pipe[j];
            adv[i] = out_ready | ~full;
        end
    end

    // Source of each stage: the array inputs for stage 0, the previous stage otherwise.
    always_comb begin
        din[0] = prod_c;
        ain[0] = pop_c;
        vin    = '0;
        vin[0] = in_valid;
        for (int s = 1; s < PIPE_STAGES; s++) begin
            din[s] = data_pipe[s-1];
            ain[s] = act_pipe[s-1];
            vin[s] = vld_pipe[s-1];
        end
    end

    // Pipeline registers: valid always follows adv, data only moves with a real beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                data_pipe[s] <= '0;
                act_pipe[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                if (flush)
                    vld_pipe[s] <= 1'b0;
                else if (adv[s])
                    vld_pipe[s] <= vin[s];
                if (adv[s] && vin[s] && !flush) begin
                    data_pipe[s] <= din[s];
                    act_pipe[s]  <= ain[s];
                end
            end
        end
    end

    // Saturating count of output handshakes; a flush edge cancels the handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            beat_count <= '0;
        else if (out_valid && out_ready && !flush && beat_count != '1)
            beat_count <= beat_count + 1'b1;
    end

    assign in_ready   = adv[0];
    assign out        = data_pipe[LAST];
    assign out_active = act_pipe[LAST];
    assign out_valid  = vld_pipe[LAST];
endmodule

// File: tb/tb_pipelined_multiplier_array.sv
// Scoreboard bench for pipelined_multiplier_array: expected beats are queued
// on input handshakes and compared lane by lane on output handshakes.
module tb_pipelined_multiplier_array;
    localparam int N  = 128;
    localparam int DW = 8;
    localparam int DO = 16;
    localparam int PS = 2;
    localparam int CW = 4;
    localparam int AW = $clog2(N+1);

    logic              clk = 1'b0;
    logic              reset, flush, in_signed, in_valid, in_ready;
    logic              out_valid, out_ready;
    logic [N*DW-1:0]   in_a, in_b;
    logic [N-1:0]      in_mask;
    logic [N*DO-1:0]   out;
    logic [AW-1:0]     out_active;
    logic [CW-1:0]     beat_count;

    always #5 clk = ~clk;

    pipelined_multiplier_array #(
        .TILE_M(4), .TILE_K(8), .TILE_N(4), .DW_IN(DW), .DW_OUT(DO),
        .PIPE_STAGES(PS), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .in_signed(in_signed),
        .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .out_active(out_active), .out_valid(out_valid),
        .out_ready(out_ready), .beat_count(beat_count)
    );

    typedef struct {
        logic [N*DO-1:0] prod;
        logic [AW-1:0]   act;
    } sb_t;

    sb_t         q[$];
    logic [15:0] exp_l0[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          mcnt    = 0;
    int          cyc     = 0;
    int          first_ov = -1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DO-1:0] mprod(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic m, input logic s);
        longint pa, pb;
        if (!m) return '0;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        return DO'(pa * pb);
    endfunction

    task automatic push_beat();
        sb_t e;
        int  c = 0;
        for (int i = 0; i < N; i++) begin
            e.prod[i*DO +: DO] = mprod(in_a[i*DW +: DW], in_b[i*DW +: DW], in_mask[i], in_signed);
            if (in_mask[i]) c++;
        end
        e.act = AW'(c);
        q.push_back(e);
    endtask

    task automatic pop_beat();
        sb_t e;
        if (q.size() == 0) begin
            chk("sb_underflow", 64'(q.size()), 1);
        end else begin
            e = q.pop_front();
            for (int i = 0; i < N; i++)
                chk($sformatf("lane%0d", i), 64'(out[i*DO +: DO]), 64'(e.prod[i*DO +: DO]));
            chk("active", 64'(out_active), 64'(e.act));
            if (exp_l0.size() > 0)
                chk("fill_lane0", 64'(out[15:0]), 64'(exp_l0.pop_front()));
        end
    endtask

    // One clock: inputs already driven at the negedge; account handshakes, then advance.
    task automatic step();
        #1;
        chk("beat_count", 64'(beat_count), 64'(mcnt));
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (out_valid && out_ready && !flush) begin
            pop_beat();
            if (mcnt < 15) mcnt++;
        end
        if (flush) q.delete();
        if (in_valid && in_ready && !flush) push_beat();
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_rand();
        for (int i = 0; i < N*DW/32; i++) begin
            in_a[i*32 +: 32] = $urandom;
            in_b[i*32 +: 32] = $urandom;
        end
        for (int i = 0; i < N/32; i++) in_mask[i*32 +: 32] = $urandom;
        in_signed = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0]      fa [4] = '{8'h03, 8'hFF, 8'hFF, 8'h80};
        logic [7:0]      fb [4] = '{8'h05, 8'hFF, 8'hFF, 8'h7F};
        logic            fs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0]     fe [4] = '{16'h000F, 16'hFE01, 16'h0001, 16'hC080};
        logic [N*DO-1:0] hold;
        logic [AW-1:0]   hold_act;
        int              acc0, qs0;
        logic [CW-1:0]   bc;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_mask = '0; in_signed = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_ready", 64'(in_ready), 1);
        chk("rst_count", 64'(beat_count), 0);
        chk("rst_active", 64'(out_active), 0);
        chk("rst_out", 64'(|out), 0);
        reset = 1'b1;
        @(negedge clk);

        // Fill: four back-to-back beats with known lane-0 results.
        acc0 = cyc;
        first_ov = -1;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_rand();
            in_a[7:0] = fa[k]; in_b[7:0] = fb[k];
            in_signed = fs[k]; in_mask[0] = 1'b1;
            exp_l0.push_back(fe[k]);
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("fill_latency", 64'(first_ov - acc0), PS);
        chk("fill_count", 64'(beat_count), 4);
        chk("fill_l0_seen", 64'(exp_l0.size()), 0);

        // Sparsity mask: alternate lanes pruned.
        for (int i = 0; i < N/32; i++) in_mask[i*32 +: 32] = 32'h5555_5555;
        for (int i = 0; i < N; i++) begin
            in_a[i*DW +: DW] = 8'h10;
            in_b[i*DW +: DW] = 8'h10;
        end
        in_signed = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("mask_valid", 64'(out_valid), 1);
        chk("mask_even", 64'(out[15:0]), 64'h0100);
        chk("mask_odd", 64'(out[31:16]), 0);
        chk("mask_top_odd", 64'(out[N*DO-1 -: DO]), 0);
        chk("mask_active", 64'(out_active), N/2);
        step();

        // Back-pressure: sink stalled for five cycles with a steady source.
        out_ready = 1'b0;
        in_valid = 1'b1;
        qs0 = q.size();
        hold = '0; hold_act = '0;
        for (int k = 0; k < 5; k++) begin
            set_rand();
            step();
            if (k == 1) begin hold = out; hold_act = out_active; end
        end
        #1;
        chk("bp_accepted", 64'(q.size() - qs0), PS);
        chk("bp_in_ready", 64'(in_ready), 0);
        chk("bp_valid", 64'(out_valid), 1);
        chk("bp_hold_out", 64'(out !== hold), 0);
        chk("bp_hold_active", 64'(out_active), 64'(hold_act));
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("bp_drained", 64'(q.size()), 0);

        // Flush with two beats in flight and a concurrent input beat.
        in_valid = 1'b1;
        set_rand(); step();
        set_rand(); step();
        bc = beat_count;
        set_rand();
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 0);
        chk("flush_count", 64'(beat_count), 64'(bc));
        for (int k = 0; k < 3; k++) begin
            chk("flush_dropped", 64'(out_valid), 0);
            step();
        end

        // Asynchronous reset between edges while a beat is on the output.
        in_valid = 1'b1;
        set_rand(); step();
        set_rand(); step();
        in_valid = 1'b0;
        chk("ar_pre_valid", 64'(out_valid), 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 0);
        chk("ar_out", 64'(|out), 0);
        chk("ar_count", 64'(beat_count), 0);
        chk("ar_ready", 64'(in_ready), 1);
        q.delete();
        mcnt = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Counter saturation: 20 handshakes on a 4-bit counter.
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin set_rand(); step(); end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("sat_count", 64'(beat_count), 15);

        // Random traffic with stalls, bubbles and occasional flushes.
        for (int k = 0; k < 80; k++) begin
            set_rand();
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 25) == 0;
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("rand_drained", 64'(q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipelined_multiplier_array.md
Name: pipelined_multiplier_array

Overview:
- Parametrised successor to the tile multiplier array for the sparse tensor core datapath.
- Computes N_UNIT independent DW_IN x DW_IN products per beat, with per-beat signed/unsigned mode and a per-lane sparsity mask.
- Masked lanes are operand-gated to zero. The configurable-depth elastic pipeline has valid/ready back-pressure, a synchronous flush and a beat counter.
- Sits between the operand distribution network and the adder tree; the adder tree may stall it.

Parameters:
TILE_M, 4, tile rows
TILE_K, 8, tile reduction depth
TILE_N, 4, tile columns
N_UNIT, TILE_M*TILE_K*TILE_N, multiplier lanes
DW_IN, 8, operand width
DW_OUT, 2*DW_IN, product width (must be >= 2*DW_IN)
PIPE_STAGES, 2, register stages from input to output (>= 1)
CNT_W, 32, beat counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous pipeline clear
in_a  input  N_UNIT*DW_IN  operand A, lane i at [i*DW_IN +: DW_IN]
in_b  input  N_UNIT*DW_IN  operand B, same packing
in_mask  input  N_UNIT  1 = lane active, 0 = lane pruned
in_signed  input  1  1 = two's-complement operands, 0 = unsigned
in_valid  input  1  input beat valid
in_ready  output  1  array can accept a beat
out  output  N_UNIT*DW_OUT  products, lane i at [i*DW_OUT +: DW_OUT]
out_active  output  $clog2(N_UNIT+1)  popcount of the beat's mask
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts
beat_count  output  CNT_W  completed output handshakes

Behaviour:
- Reset (reset low, asynchronous): all stage valid bits 0, all data registers 0, beat_count 0. Therefore out=0, out_active=0, out_valid=0 and in_ready=1 once any reset release occurs.
- Stage structure: stage 0 registers the products, mask popcount and valid. Stages 1..PIPE_STAGES-1 delay these unchanged. The last stage drives the outputs.
- Advance rule:
  - adv[last] = out_ready | ~v[last].
  - adv[i] = adv[i+1] | ~v[i].
  - in_ready = adv[0].
  - Stage i loads from stage i-1 (or the input) when adv[i]. Otherwise it holds both data and valid.
  - There are no bubbles when out_ready is held high.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+PIPE_STAGES-1, i.e. it is present for PIPE_STAGES cycles including its first register stage. With PIPE_STAGES=1, products are registered once.
- Throughput: 1 beat/cycle. Capacity is PIPE_STAGES beats. The in_ready path is combinational from out_ready.
- Arithmetic:
  - in_signed=1: both operands are sign-extended and the product is the exact two's-complement value, sign-extended to DW_OUT.
  - in_signed=0: zero-extended.
  - Example with DW_IN=8: 0xFF*0xFF gives 0xFE01 unsigned and 0x0001 signed. 0x80*0x7F signed gives 0xC080.
- Masking: a lane with in_mask=0 presents operands 0 to its multiplier (operand gating). Its product is 0 regardless of in_a/in_b.
- out_active is the popcount of in_mask, carried with the beat. It is meaningful only when out_valid=1.
- Mode and mask are per beat: captured with the beat and never shared across beats.
- Flush: on an edge with flush=1, all valid bits clear and the input beat is not accepted, even if in_valid and in_ready are both 1. Data registers may retain values. beat_count is unaffected. A handshake at the output on the same edge does not count.
- beat_count: +1 on each edge with out_valid & out_ready & ~flush. It saturates at all-ones (no wrap).
- Output stability: while out_valid=1 and out_ready=0, out and out_active must hold stable.
- in_valid=0 with in_ready=1 inserts a bubble (valid 0). Data registers need not change.
- Reset asserted mid-stream: pending beats are discarded immediately (asynchronous) and the counter returns to 0.

Test Plan:
- Reset + fill:
  - Stimulus: PIPE_STAGES=2, deassert reset, drive 4 back-to-back beats with lane0 = (3,5), (0xFF,0xFF) unsigned, (0xFF,0xFF) signed, (0x80,0x7F) signed. Hold out_ready=1.
  - Required: out_valid first rises 2 cycles after the first acceptance. Lane0 outputs are 0x000F, 0xFE01, 0x0001, 0xC080. beat_count=4.
- Sparsity mask:
  - Stimulus: in_mask=0x55555555..., all operands 0x10.
  - Required: even lanes give 0x0100, odd lanes give 0. out_active=N_UNIT/2 (64).
- Back-pressure:
  - Stimulus: out_ready=0 for 5 cycles while in_valid=1.
  - Required: exactly PIPE_STAGES beats accepted, then in_ready=0. out holds stable. After out_ready=1, beats drain in order with no loss or duplication.
- Flush:
  - Stimulus: 2 beats in flight, pulse flush with in_valid=1.
  - Required: out_valid=0 the next cycle. The concurrent input beat is dropped. beat_count unchanged.
- Asynchronous reset mid-stream:
  - Stimulus: assert reset between clock edges while out_valid=1.
  - Required: out_valid, out and beat_count go to 0 immediately, without waiting for a clock edge.
- Counter saturation:
  - Stimulus: CNT_W=4, 20 handshakes.
  - Required: beat_count stops at 15.
